// File: rtl/tpu_pkg.sv
// Shared constants for the systolic-array operand path: mux select codes,
// staging slot numbers and a helper for the load-completion test.
package tpu_pkg;

    localparam int NUM_SLOTS = 8;

    // Operand select codes driven by control_unit
    localparam logic [1:0] SEL_0    = 2'd0;
    localparam logic [1:0] SEL_1    = 2'd1;
    localparam logic [1:0] SEL_ZERO = 2'd2;

    // Staging slots: weights W0..W3 (A row-major), inputs X0..X3 (B row-major)
    localparam int SLOT_W0 = 0;
    localparam int SLOT_W1 = 1;
    localparam int SLOT_W2 = 2;
    localparam int SLOT_W3 = 3;
    localparam int SLOT_X0 = 4;
    localparam int SLOT_X1 = 5;
    localparam int SLOT_X2 = 6;
    localparam int SLOT_X3 = 7;

    localparam logic [2:0] LAST_SLOT = 3'd7;

    // A set is complete when every slot except the last has been written;
    // the last slot is supplied by the byte arriving on the same edge.
    function automatic logic set_complete(input logic [NUM_SLOTS-1:0] mask);
        return ((mask | 8'h80) == 8'hFF);
    endfunction

endpackage

// File: rtl/operand_buffer_mux.sv
// One operand lane: picks one of two fixed bank slots by select code,
// forcing zero for codes 2/3 or when the active bank is not yet valid.
module operand_mux
    import tpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int SLOT_A = 0,
    parameter int SLOT_B = 1
) (
    input  logic [NUM_SLOTS*DATA_W-1:0] i_bank,
    input  logic                        i_valid,
    input  logic [1:0]                  i_sel,
    output logic [DATA_W-1:0]           o_operand
);

    logic [DATA_W-1:0] w_pick;

    // Walk the bank and OR in only the slot matching the select code
    always_comb begin
        w_pick = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if ((k == SLOT_A && i_sel == SEL_0) || (k == SLOT_B && i_sel == SEL_1)) begin
                w_pick = w_pick | i_bank[k*DATA_W +: DATA_W];
            end
        end
        if (!i_valid) begin
            w_pick = '0;
        end
    end

    assign o_operand = w_pick;

endmodule

// File: rtl/operand_buffer.sv
// Double-buffered operand store feeding the 2x2 systolic array. Serial
// bytes fill a staging bank; a complete set is committed to the active bank
// on the last-slot write, and the four edge operands are registered from the
// active bank every cycle.
module operand_buffer
    import tpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic [2:0]        mem_addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic [1:0]        a0_sel,
    input  logic [1:0]        a1_sel,
    input  logic [1:0]        b0_sel,
    input  logic [1:0]        b1_sel,
    output logic [DATA_W-1:0] a0,
    output logic [DATA_W-1:0] a1,
    output logic [DATA_W-1:0] b0,
    output logic [DATA_W-1:0] b1,
    output logic              commit,
    output logic              bank_valid,
    output logic              load_err
);

    logic [NUM_SLOTS*DATA_W-1:0] r_stage;
    logic [NUM_SLOTS*DATA_W-1:0] r_bank;
    logic [NUM_SLOTS-1:0]        r_written;
    logic                        r_bank_valid;
    logic                        r_commit;
    logic                        r_load_err;
    logic                        r_load_en_d;
    logic [DATA_W-1:0]           r_a0, r_a1, r_b0, r_b1;

    logic              w_last;
    logic              w_commit;
    logic              w_incomplete;
    logic              w_abort;
    logic [DATA_W-1:0] w_a0, w_a1, w_b0, w_b1;

    assign w_last       = load_en && (mem_addr == LAST_SLOT);
    assign w_commit     = w_last && set_complete(r_written);
    assign w_incomplete = w_last && !set_complete(r_written);
    // A falling load_en with bytes pending means the set was abandoned;
    // any commit or slot-7 error already cleared the mask, so no overlap.
    assign w_abort      = r_load_en_d && !load_en && (r_written != '0);

    // Staging bank and written mask; the mask clears on every set boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage     <= '0;
            r_written   <= '0;
            r_load_en_d <= 1'b0;
        end else begin
            r_load_en_d <= load_en;
            if (load_en) begin
                r_stage[int'(mem_addr)*DATA_W +: DATA_W] <= data_in;
            end
            if (w_last || w_abort) begin
                r_written <= '0;
            end else if (load_en) begin
                r_written[mem_addr] <= 1'b1;
            end
        end
    end

    // Active bank: the last byte bypasses staging so the commit takes one edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bank       <= '0;
            r_bank_valid <= 1'b0;
        end else if (w_commit) begin
            r_bank       <= {data_in, r_stage[(NUM_SLOTS-1)*DATA_W-1:0]};
            r_bank_valid <= 1'b1;
        end
    end

    // Single-cycle status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_commit   <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_commit   <= w_commit;
            r_load_err <= w_incomplete || w_abort;
        end
    end

    operand_mux #(.DATA_W(DATA_W), .SLOT_A(SLOT_W0), .SLOT_B(SLOT_W1)) u_mux_a0 (
        .i_bank(r_bank), .i_valid(r_bank_valid), .i_sel(a0_sel), .o_operand(w_a0)
    );
    operand_mux #(.DATA_W(DATA_W), .SLOT_A(SLOT_W2), .SLOT_B(SLOT_W3)) u_mux_a1 (
        .i_bank(r_bank), .i_valid(r_bank_valid), .i_sel(a1_sel), .o_operand(w_a1)
    );
    operand_mux #(.DATA_W(DATA_W), .SLOT_A(SLOT_X0), .SLOT_B(SLOT_X2)) u_mux_b0 (
        .i_bank(r_bank), .i_valid(r_bank_valid), .i_sel(b0_sel), .o_operand(w_b0)
    );
    operand_mux #(.DATA_W(DATA_W), .SLOT_A(SLOT_X1), .SLOT_B(SLOT_X3)) u_mux_b1 (
        .i_bank(r_bank), .i_valid(r_bank_valid), .i_sel(b1_sel), .o_operand(w_b1)
    );

    // Operand registers read the pre-commit bank, so a same-edge commit is
    // only visible from the following cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a0 <= '0;
            r_a1 <= '0;
            r_b0 <= '0;
            r_b1 <= '0;
        end else begin
            r_a0 <= w_a0;
            r_a1 <= w_a1;
            r_b0 <= w_b0;
            r_b1 <= w_b1;
        end
    end

    assign a0         = r_a0;
    assign a1         = r_a1;
    assign b0         = r_b0;
    assign b1         = r_b1;
    assign commit     = r_commit;
    assign bank_valid = r_bank_valid;
    assign load_err   = r_load_err;

endmodule

// File: tb/tb_operand_buffer.sv
// Self-checking bench for operand_buffer: a reference model of the active
// bank predicts registered operands into a scoreboard queue, and each
// scenario task pops and compares them alongside hand-derived pulse checks.
module tb_operand_buffer;

    typedef struct packed {
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] b0;
        logic [7:0] b1;
    } ops_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       load_en = 1'b0;
    logic [2:0] mem_addr = '0;
    logic [7:0] data_in = '0;
    logic [1:0] a0_sel = 2'd2, a1_sel = 2'd2, b0_sel = 2'd2, b1_sel = 2'd2;
    logic [7:0] a0, a1, b0, b1;
    logic       commit, bank_valid, load_err;

    int checks = 0;
    int errors = 0;

    ops_t       sb_q[$];
    ops_t       exp_o;
    logic [7:0] m_stage[8];
    logic [7:0] m_bank[8];
    logic [7:0] m_mask;
    logic       m_valid;
    logic       m_prev_le;

    operand_buffer #(.DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .load_en(load_en), .mem_addr(mem_addr),
        .data_in(data_in), .a0_sel(a0_sel), .a1_sel(a1_sel), .b0_sel(b0_sel),
        .b1_sel(b1_sel), .a0(a0), .a1(a1), .b0(b0), .b1(b1),
        .commit(commit), .bank_valid(bank_valid), .load_err(load_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [7:0] pick(input logic [1:0] s, input int lo, input int hi);
        if (!m_valid) return 8'h00;
        case (s)
            2'd0:    return m_bank[lo];
            2'd1:    return m_bank[hi];
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            m_stage[i] = 8'h00;
            m_bank[i]  = 8'h00;
        end
        m_mask    = 8'h00;
        m_valid   = 1'b0;
        m_prev_le = 1'b0;
        sb_q.delete();
    endtask

    // Drive one cycle of stimulus, predict the registered operands for this
    // edge into the scoreboard, advance the model, and stop #1 past the edge.
    task automatic cyc(input logic le, input logic [2:0] addr, input logic [7:0] d,
                       input logic [1:0] s0, input logic [1:0] s1,
                       input logic [1:0] s2, input logic [1:0] s3);
        ops_t e;
        load_en = le; mem_addr = addr; data_in = d;
        a0_sel = s0; a1_sel = s1; b0_sel = s2; b1_sel = s3;
        e.a0 = pick(s0, 0, 1);
        e.a1 = pick(s1, 2, 3);
        e.b0 = pick(s2, 4, 6);
        e.b1 = pick(s3, 5, 7);
        sb_q.push_back(e);
        if (le && addr == 3'd7) begin
            if ((m_mask | 8'h80) == 8'hFF) begin
                for (int i = 0; i < 7; i++) m_bank[i] = m_stage[i];
                m_bank[7] = d;
                m_valid   = 1'b1;
            end
            m_stage[7] = d;
            m_mask     = 8'h00;
        end else if (le) begin
            m_stage[addr] = d;
            m_mask[addr]  = 1'b1;
        end else if (m_prev_le && m_mask != 8'h00) begin
            m_mask = 8'h00;
        end
        m_prev_le = le;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({a0, a1, b0, b1} !== 32'h0) begin errors++; $display("FAIL reset_ops: got %h want 00000000", {a0, a1, b0, b1}); end
        checks++; if ({commit, bank_valid, load_err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {commit, bank_valid, load_err}); end
        model_clear();
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_full_set();
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 3'(i), 8'(i + 1), 2'd0, 2'd1, 2'd0, 2'd1);
            exp_o = sb_q.pop_front();
            checks++; if ({a0, a1, b0, b1} !== exp_o) begin errors++; $display("FAIL full_set_ops[%0d]: got %h want %h", i, {a0, a1, b0, b1}, exp_o); end
            if (i < 7) begin
                checks++; if (commit !== 1'b0) begin errors++; $display("FAIL full_set_early_commit[%0d]: got %b want 0", i, commit); end
            end
        end
        checks++; if (commit !== 1'b1) begin errors++; $display("FAIL full_set_commit: got %b want 1", commit); end
        checks++; if (bank_valid !== 1'b1) begin errors++; $display("FAIL full_set_valid: got %b want 1", bank_valid); end
        cyc(1'b0, 3'd0, 8'h00, 2'd0, 2'd2, 2'd2, 2'd1);
        exp_o = sb_q.pop_front();
        checks++; if ({a0, a1, b0, b1} !== exp_o) begin errors++; $display("FAIL readback_ops: got %h want %h", {a0, a1, b0, b1}, exp_o); end
        checks++; if (a0 !== 8'd1 || b1 !== 8'd8) begin errors++; $display("FAIL readback_a0_b1: got %0d/%0d want 1/8", a0, b1); end
        checks++; if (commit !== 1'b0 || load_err !== 1'b0) begin errors++; $display("FAIL readback_pulses: got commit %b err %b want 0 0", commit, load_err); end
    endtask

    task automatic test_mapping();
        logic [31:0] want[3];
        want[0] = {8'd1, 8'd3, 8'd5, 8'd6};
        want[1] = {8'd2, 8'd4, 8'd7, 8'd8};
        want[2] = 32'h0;
        for (int s = 0; s < 3; s++) begin
            cyc(1'b0, 3'd0, 8'h00, 2'(s), 2'(s), 2'(s), 2'(s));
            exp_o = sb_q.pop_front();
            checks++; if ({a0, a1, b0, b1} !== exp_o) begin errors++; $display("FAIL mapping_sb[%0d]: got %h want %h", s, {a0, a1, b0, b1}, exp_o); end
            checks++; if ({a0, a1, b0, b1} !== want[s]) begin errors++; $display("FAIL mapping_sel%0d: got %h want %h", s, {a0, a1, b0, b1}, want[s]); end
        end
        cyc(1'b0, 3'd0, 8'h00, 2'd3, 2'd3, 2'd3, 2'd3);
        exp_o = sb_q.pop_front();
        checks++; if ({a0, a1, b0, b1} !== 32'h0) begin errors++; $display("FAIL mapping_sel3: got %h want 00000000", {a0, a1, b0, b1}); end
    endtask

    task automatic test_abort();
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 3'(i), 8'(8'h10 + i), 2'd0, 2'd0, 2'd0, 2'd0);
            exp_o = sb_q.pop_front();
            checks++; if ({a0, a1, b0, b1} !== exp_o) begin errors++; $display("FAIL abort_load_ops[%0d]: got %h want %h", i, {a0, a1, b0, b1}, exp_o); end
        end
        checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL abort_early_err: got %b want 0", load_err); end
        cyc(1'b0, 3'd0, 8'h00, 2'd0, 2'd0, 2'd0, 2'd0);
        exp_o = sb_q.pop_front();
        checks++; if (load_err !== 1'b1) begin errors++; $display("FAIL abort_err_pulse: got %b want 1", load_err); end
        checks++; if (bank_valid !== 1'b1 || commit !== 1'b0) begin errors++; $display("FAIL abort_bank_state: got valid %b commit %b want 1 0", bank_valid, commit); end
        cyc(1'b0, 3'd0, 8'h00, 2'd0, 2'd0, 2'd0, 2'd0);
        exp_o = sb_q.pop_front();
        checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL abort_err_single: got %b want 0", load_err); end
        checks++; if ({a0, a1, b0, b1} !== {8'd1, 8'd3, 8'd5, 8'd6}) begin errors++; $display("FAIL abort_bank_kept: got %h want 01030506", {a0, a1, b0, b1}); end
    endtask

    task automatic test_double_buffer();
        // Set B streams while selects alternate; operands must still show A
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 3'(i), 8'(8'h20 + i), 2'(i % 2), 2'(i % 2), 2'(i % 2), 2'(i % 2));
            exp_o = sb_q.pop_front();
            checks++; if ({a0, a1, b0, b1} !== exp_o) begin errors++; $display("FAIL dbuf_b_ops[%0d]: got %h want %h", i, {a0, a1, b0, b1}, exp_o); end
        end
        checks++; if (a0 !== 8'd2 || commit !== 1'b1) begin errors++; $display("FAIL dbuf_b_commit: got a0 %h commit %b want 02 1", a0, commit); end
        // Set C follows with no bubble; operands now show B
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 3'(i), 8'(8'h30 + i), 2'd1, 2'd1, 2'd1, 2'd1);
            exp_o = sb_q.pop_front();
            checks++; if ({a0, a1, b0, b1} !== exp_o) begin errors++; $display("FAIL dbuf_c_ops[%0d]: got %h want %h", i, {a0, a1, b0, b1}, exp_o); end
            if (i == 0) begin
                checks++; if (commit !== 1'b0) begin errors++; $display("FAIL dbuf_commit_single: got %b want 0", commit); end
            end
        end
        checks++; if ({a0, a1, b0, b1} !== 32'h21232627 || commit !== 1'b1) begin errors++; $display("FAIL dbuf_collision: got %h commit %b want 21232627 1", {a0, a1, b0, b1}, commit); end
        cyc(1'b0, 3'd0, 8'h00, 2'd1, 2'd1, 2'd1, 2'd1);
        exp_o = sb_q.pop_front();
        checks++; if ({a0, a1, b0, b1} !== 32'h31333637 || load_err !== 1'b0) begin errors++; $display("FAIL dbuf_c_visible: got %h err %b want 31333637 0", {a0, a1, b0, b1}, load_err); end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 3'(i), 8'(8'h40 + i), 2'd0, 2'd0, 2'd0, 2'd0);
            exp_o = sb_q.pop_front();
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({a0, a1, b0, b1} !== 32'h0 || {commit, bank_valid, load_err} !== 3'b000) begin errors++; $display("FAIL midreset_async: got %h flags %b want 0 000", {a0, a1, b0, b1}, {commit, bank_valid, load_err}); end
        model_clear();
        @(posedge clk); #1 rst_n = 1'b1;
        cyc(1'b0, 3'd0, 8'h00, 2'd0, 2'd1, 2'd0, 2'd1);
        exp_o = sb_q.pop_front();
        checks++; if ({a0, a1, b0, b1} !== exp_o) begin errors++; $display("FAIL midreset_ops: got %h want %h", {a0, a1, b0, b1}, exp_o); end
        checks++; if (load_err !== 1'b0 || bank_valid !== 1'b0) begin errors++; $display("FAIL midreset_flags: got err %b valid %b want 0 0", load_err, bank_valid); end
    endtask

    task automatic test_incomplete();
        for (int i = 0; i < 8; i++) begin
            if (i != 3) begin
                cyc(1'b1, 3'(i), 8'(8'h50 + i), 2'd0, 2'd0, 2'd0, 2'd0);
                exp_o = sb_q.pop_front();
                checks++; if ({a0, a1, b0, b1} !== exp_o) begin errors++; $display("FAIL incomplete_ops[%0d]: got %h want %h", i, {a0, a1, b0, b1}, exp_o); end
            end
        end
        checks++; if (load_err !== 1'b1 || commit !== 1'b0) begin errors++; $display("FAIL incomplete_err: got err %b commit %b want 1 0", load_err, commit); end
        checks++; if (bank_valid !== 1'b0) begin errors++; $display("FAIL incomplete_valid: got %b want 0", bank_valid); end
        // A clean set afterward still commits
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 3'(i), 8'(8'h60 + i), 2'd0, 2'd0, 2'd0, 2'd0);
            exp_o = sb_q.pop_front();
            if (i == 0) begin
                checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL incomplete_err_single: got %b want 0", load_err); end
            end
        end
        checks++; if (commit !== 1'b1 || bank_valid !== 1'b1) begin errors++; $display("FAIL recover_commit: got commit %b valid %b want 1 1", commit, bank_valid); end
        cyc(1'b0, 3'd0, 8'h00, 2'd1, 2'd1, 2'd1, 2'd1);
        exp_o = sb_q.pop_front();
        checks++; if ({a0, a1, b0, b1} !== exp_o || a0 !== 8'h61) begin errors++; $display("FAIL recover_ops: got %h want %h", {a0, a1, b0, b1}, exp_o); end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_full_set();
        test_mapping();
        test_abort();
        test_double_buffer();
        test_reset_midstream();
        test_incomplete();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
